// File: rtl/tone_seq_pkg.sv
// Shared definitions for the tone sequencer: FSM state encoding and timing constants.
// No ports (package). GAP_TICKS applies only when TONE_SEQ_GAP_EN is defined.
// REST_HALF is the half-period value that marks a silent (rest) step.
package tone_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NOTE = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_e;

  // Silent ticks inserted after every note when the gap feature is built in.
  localparam int GAP_TICKS = 2;

  // A half-period of zero means "rest": the buzzer stays low for the note.
  localparam int REST_HALF = 0;

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles sq every `half` clk cycles, giving period 2*half.
// Ports: clk/rst (async active-high), en (run), half (half-period, 0 = rest),
//        clear (restart phase, forces sq low next cycle), sq (registered output).
module tone_gen
  import tone_seq_pkg::*;
#(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PER_W-1:0] half,
  input  logic             clear,
  output logic             sq
);

  logic [PER_W-1:0] cnt_q;
  logic             sq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else if (clear || !en || (half == PER_W'(REST_HALF))) begin
      // Holding the counter at zero with sq low means the first cycle of
      // every note starts low and a full half-period elapses before the rise.
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else if (cnt_q == (half - 1'b1)) begin
      cnt_q <= '0;
      sq_q  <= ~sq_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sq = sq_q;

endmodule

// File: rtl/tone_sequencer.sv
// Pattern-table tone sequencer: plays steps 0..last_step, each a {half, dur} note,
// with optional looping; ticks are TICK_DIV clk cycles. Optional feature macro:
// TONE_SEQ_GAP_EN (adds a silent GAP of GAP_TICKS ticks after every note).
// Ports: clk, rst (async active-high); start/stop/loop/last_step control;
//        wr_en/wr_addr/wr_half/wr_dur table write; buzzer/busy/step/done outputs.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int  TICK_DIV = 1000,
  parameter int  STEPS    = 16,
  parameter int  PER_W    = 16,
  parameter int  DUR_W    = 12,
  localparam int AW       = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [AW-1:0]    last_step,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PER_W-1:0] wr_half,
  input  logic [DUR_W-1:0] wr_dur,
  output logic             buzzer,
  output logic             busy,
  output logic [AW-1:0]    step,
  output logic             done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Pattern table
  logic [PER_W-1:0] tbl_half_q [STEPS];
  logic [DUR_W-1:0] tbl_dur_q  [STEPS];

  // Sequencer state
  seq_state_e       state_q;
  logic             busy_q;
  logic             done_q;
  logic [AW-1:0]    step_q;
  logic [AW-1:0]    last_q;
  logic [PER_W-1:0] half_q;
  logic [DUR_W-1:0] dur_q;
  logic [TW-1:0]    tick_cnt_q;
  logic [DUR_W-1:0] tick_num_q;

  logic             tick;
  logic [DUR_W-1:0] dur_last;
  logic             note_end;
  logic             seg_end;
  logic             at_last;
  logic [AW-1:0]    nxt_step_d;
  logic             tone_clr;
  logic             tone_en;
  logic             tone_sq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        tbl_half_q[i] <= '0;
        tbl_dur_q[i]  <= '0;
      end
    end else if (wr_en) begin
      tbl_half_q[wr_addr] <= wr_half;
      tbl_dur_q[wr_addr]  <= wr_dur;
    end
  end

  assign tick     = (tick_cnt_q == TW'(TICK_DIV - 1));
  // A zero duration plays as a single tick.
  assign dur_last = (dur_q == '0) ? '0 : (dur_q - 1'b1);
  assign note_end = (state_q == ST_NOTE) && tick && (tick_num_q == dur_last);

`ifdef TONE_SEQ_GAP_EN
  // The step boundary moves to the end of the trailing silence.
  assign seg_end = (state_q == ST_GAP) && tick && (tick_num_q == DUR_W'(GAP_TICKS - 1));
`else
  assign seg_end = note_end;
`endif

  assign at_last    = (step_q == last_q);
  assign nxt_step_d = at_last ? '0 : (step_q + 1'b1);
  assign tone_clr   = stop || note_end;
  assign tone_en    = (state_q == ST_NOTE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= '0;
      last_q     <= '0;
      half_q     <= '0;
      dur_q      <= '0;
      tick_cnt_q <= '0;
      tick_num_q <= '0;
    end else begin
      done_q     <= 1'b0;
      tick_cnt_q <= tick ? '0 : (tick_cnt_q + 1'b1);
      if (tick) begin
        tick_num_q <= tick_num_q + 1'b1;
      end

      if (stop) begin
        state_q    <= ST_IDLE;
        busy_q     <= 1'b0;
        step_q     <= '0;
        tick_cnt_q <= '0;
        tick_num_q <= '0;
      end else if (state_q == ST_IDLE) begin
        tick_cnt_q <= '0;
        tick_num_q <= '0;
        if (start) begin
          state_q <= ST_NOTE;
          busy_q  <= 1'b1;
          step_q  <= '0;
          last_q  <= last_step;
          half_q  <= tbl_half_q[0];
          dur_q   <= tbl_dur_q[0];
        end
      end else if (seg_end) begin
        tick_cnt_q <= '0;
        tick_num_q <= '0;
        if (!at_last || loop) begin
          // Entry is captured here so later table writes cannot disturb it.
          state_q <= ST_NOTE;
          step_q  <= nxt_step_d;
          half_q  <= tbl_half_q[nxt_step_d];
          dur_q   <= tbl_dur_q[nxt_step_d];
        end else begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          step_q  <= '0;
        end
      end
`ifdef TONE_SEQ_GAP_EN
      else if (note_end) begin
        state_q    <= ST_GAP;
        tick_cnt_q <= '0;
        tick_num_q <= '0;
      end
`endif
    end
  end

  tone_gen #(
    .PER_W (PER_W)
  ) u_tone_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (tone_en),
    .half  (half_q),
    .clear (tone_clr),
    .sq    (tone_sq)
  );

  assign buzzer = tone_sq;
  assign busy   = busy_q;
  assign step   = step_q;
  assign done   = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer (TICK_DIV=4, STEPS=4).
// Expected per-cycle outputs are queued by the stimulus; a negedge monitor pops and compares.
// Works with or without TONE_SEQ_GAP_EN (expected traces insert the gap when defined).
module tb_tone_sequencer;

  localparam int TD = 4;
`ifdef TONE_SEQ_GAP_EN
  localparam int GAPC = 2 * TD;
`else
  localparam int GAPC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [1:0]  last_step = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [15:0] wr_half = '0;
  logic [11:0] wr_dur = '0;
  logic        buzzer;
  logic        busy;
  logic [1:0]  step;
  logic        done;

  tone_sequencer #(
    .TICK_DIV (TD),
    .STEPS    (4),
    .PER_W    (16),
    .DUR_W    (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .last_step (last_step),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_half   (wr_half),
    .wr_dur    (wr_dur),
    .buzzer    (buzzer),
    .busy      (busy),
    .step      (step),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sc;
    logic       busy;
    logic       buz;
    logic [1:0] st;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   errs = 0;
  int   checks = 0;
  int   sc_id = 0;
  int   pops = 0;
  int   cyc = 0;
  int   t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  // Monitor: one comparison per cycle while expectations are pending.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pops++;
      chk($sformatf("sc%0d_cyc%0d {busy,buz,step,done}", e.sc, pops),
          32'({busy, buzzer, step, done}), 32'({e.busy, e.buz, e.st, e.done}));
    end
  end

  task automatic push(input logic b, input logic z, input logic [1:0] s, input logic d);
    exp_t e;
    e.sc = 8'(sc_id); e.busy = b; e.buz = z; e.st = s; e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  // Sounding cycles: buzzer is low for the first half-period, then alternates.
  task automatic push_cycles(input int half, input int n, input int s);
    for (int i = 0; i < n; i++)
      push(1'b1, (half == 0) ? 1'b0 : (((i / half) % 2) == 1), 2'(s), 1'b0);
  endtask

  task automatic push_note(input int half, input int dur, input int s);
    push_cycles(half, ((dur == 0) ? 1 : dur) * TD, s);
    for (int i = 0; i < GAPC; i++) push(1'b1, 1'b0, 2'(s), 1'b0);
  endtask

  task automatic push_done();
    push(1'b0, 1'b0, 2'd0, 1'b1);
    push(1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic wr(input int a, input int h, input int d);
    wr_en = 1'b1; wr_addr = 2'(a); wr_half = 16'(h); wr_dur = 12'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic go(input int last, input logic lp);
    last_step = 2'(last); loop = lp; start = 1'b1;
    t0 = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns just after the edge that begins note cycle c (cycle 0 = first NOTE cycle).
  task automatic wait_nc(input int c);
    while (cyc < t0 + c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(posedge clk); n++;
    end
    #1;
    if (exp_q.size() > 0) begin
      errs++; checks++;
      $display("FAIL drain_timeout sc%0d pending=%0d want=0", sc_id, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk("reset_busy",   32'(busy),   32'd0);
    chk("reset_buzzer", 32'(buzzer), 32'd0);
    chk("reset_step",   32'(step),   32'd0);
    chk("reset_done",   32'(done),   32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // 1: single note half=2 dur=3, 12 busy cycles then done
    wr(0, 2, 3);
    sc_id = 1; push_idle(1); push_note(2, 3, 0); push_done();
    go(0, 1'b0);
    drain();

    // 2: rest then half=3; start and last_step changes mid-play are ignored
    wr(0, 0, 1); wr(1, 3, 2);
    sc_id = 2; push_idle(1); push_note(0, 1, 0); push_note(3, 2, 1); push_done();
    go(1, 1'b0);
    wait_nc(1);
    start = 1'b1; last_step = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // 3: loop twice, drop loop during second pass of step 1
    sc_id = 3; push_idle(1);
    push_note(0, 1, 0); push_note(3, 2, 1); push_note(0, 1, 0); push_note(3, 2, 1);
    push_done();
    go(1, 1'b1);
    wait_nc(4 + GAPC + 8 + GAPC + 4 + GAPC + 2);
    loop = 1'b0;
    drain();

    // 4: stop mid-note in step 1 (buzzer high at that moment), no done
    sc_id = 4; push_idle(1); push_note(0, 1, 0); push_cycles(3, 4, 1); push_idle(3);
    go(1, 1'b0);
    wait_nc(4 + GAPC + 3);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    drain();

    // 8: stop wins over a simultaneous start
    sc_id = 8; push_idle(4);
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    drain();

    // 5: rewrite step 0 while it sounds; new value heard on the next pass
    wr(0, 2, 2); wr(1, 0, 1);
    sc_id = 5; push_idle(1);
    push_note(2, 2, 0); push_note(0, 1, 1); push_note(1, 2, 0); push_note(0, 1, 1);
    push_done();
    go(1, 1'b1);
    wait_nc(2);
    wr(0, 1, 2);
    wait_nc(8 + GAPC + 4 + GAPC + 8 + GAPC + 1);
    loop = 1'b0;
    drain();

    // 6: step0={2,1}: 4 note cycles (+8 gap cycles when built in), then done
    wr(0, 2, 1);
    sc_id = 6; push_idle(1); push_note(2, 1, 0); push_done();
    go(0, 1'b0);
    drain();

    // 7: zero duration plays as one tick, half=1 toggles every cycle
    wr(0, 1, 0);
    sc_id = 7; push_idle(1); push_note(1, 0, 0); push_done();
    go(0, 1'b0);
    drain();

    // 9: reset mid-playback aborts at once and clears the table
    wr(0, 2, 3);
    sc_id = 9;
    go(0, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy",   32'(busy),   32'd0);
    chk("midrst_buzzer", 32'(buzzer), 32'd0);
    chk("midrst_step",   32'(step),   32'd0);
    chk("midrst_done",   32'(done),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 10: cleared entry 0 is {0,0}: silent single tick, then done
    sc_id = 10; push_idle(1); push_note(0, 0, 0); push_done();
    go(0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 TICK_DIV, 1000, clk cycles per duration tick; SHALL be ≥1.
REQ-002 STEPS, 16, pattern table depth; SHALL be a power of two ≥2. AW = log2(STEPS).
REQ-003 PER_W, 16, width of tone half-period field.
REQ-004 DUR_W, 12, width of note-duration field in ticks.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  single-cycle request to begin playback from step 0.
REQ-008 stop  in  1  abort playback.
REQ-009 loop  in  1  1 = wrap to step 0 after last_step; sampled at the last step's end.
REQ-010 last_step  in  AW  index of the final pattern step; sampled at start.
REQ-011 wr_en  in  1  table write strobe.
REQ-012 wr_addr  in  AW  table write index.
REQ-013 wr_half  in  PER_W  tone half-period in clk cycles; 0 = rest.
REQ-014 wr_dur  in  DUR_W  note duration in ticks; 0 is treated as 1.
REQ-015 buzzer  out  1  square-wave output.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 step  out  AW  index of the step currently sounding.
REQ-018 done  out  1  one-cycle pulse on normal (non-loop) completion.

Function
REQ-019 States: IDLE, NOTE, and GAP (GAP only with the macro). All outputs are registered.
- IDLE + start=1 → NOTE next cycle, with step=0 and step-0 entry latched.
- start while busy: ignored.
REQ-020 On entering NOTE, the current entry {half, dur} SHALL be latched. A later write to the same address does not affect the sounding note.
REQ-021 Tick prescaler:
- Counts 0..TICK_DIV-1 while busy, emitting a tick at TICK_DIV-1.
- Cleared in IDLE and at every step change.
REQ-022 Note ends on the dur-th tick, where a dur of 0 counts as 1.
- NOTE lasts exactly max(dur,1)*TICK_DIV cycles.
- On the end cycle: if step<last_step, step+1 is loaded.
- If step==last_step and loop=1: step 0 is loaded.
- Otherwise: return to IDLE, done=1 for one cycle, busy=0 in the same cycle.
REQ-023 Tone generation (half≠0):
- Half-period counter counts 0..half-1; buzzer toggles when the counter reaches half-1.
- buzzer SHALL be 0 on the first NOTE cycle.
- Output period SHALL be 2*half cycles.
- Counter and buzzer are cleared at each step change.
REQ-024 A rest (half=0) SHALL hold buzzer=0 for the full duration.
REQ-025 stop=1 in any state: next cycle IDLE, buzzer=0, step=0, and done SHALL NOT pulse. stop takes priority over start and over step end.
REQ-026 Table writes SHALL be accepted in any state and complete in one cycle.
REQ-027 last_step is latched at start; changes during playback SHALL have no effect until the next start.

Reset
REQ-028 rst SHALL force IDLE with buzzer=0, busy=0, step=0, done=0, and all counters cleared.
REQ-029 rst SHALL clear all table entries to {half=0, dur=0}.
REQ-030 rst mid-playback SHALL abort immediately, with no done pulse.

Configuration
REQ-031 With TONE_SEQ_GAP_EN defined:
- Each NOTE is followed by GAP for GAP_TICKS ticks (package constant, 2) with buzzer=0.
- step holds during GAP; the step advance or done occurs at GAP end.
- The GAP is inserted after the final step as well.
REQ-032 Without TONE_SEQ_GAP_EN: there is no GAP state, notes are back-to-back, and timing follows REQ-022.

Structure
REQ-033 Package tone_seq_pkg SHALL hold the state encoding, GAP_TICKS, and the REST_HALF=0 constant.
REQ-034 Tone generation SHALL be the sub-module tone_gen (inputs: en, half, clear; output: sq). The sequencer instantiates it once.

Verification
REQ-035 Common settings: TICK_DIV=4, STEPS=4, with the macro undefined unless stated.
- Scenario 1: write step0={half=2, dur=3}, last_step=0, loop=0, pulse start.
  - busy for 12 cycles.
  - buzzer toggles every 2 cycles, starting low.
  - done pulses once at cycle 12; then IDLE.
- Scenario 2: write step0={0,1}, step1={3,2}, last_step=1.
  - buzzer=0 for 4 cycles, then a period-6 wave for 8 cycles.
  - step reads 0 then 1.
- Scenario 3: loop=1, last_step=1.
  - step sequence 0,1,0,1…; no done.
  - Drop loop to 0 during step 1: done pulses at the end of step 1.
- Scenario 4: assert stop mid-note in step 1.
  - Next cycle: buzzer=0, busy=0, step=0, no done.
- Scenario 5: during step 0, write step0 with a new half value.
  - The current note keeps the old period; the next loop pass uses the new value.
- Scenario 6 (macro defined): step0={2,1}, last_step=0.
  - 4 NOTE cycles, then 8 silent GAP cycles.
  - done at cycle 12.
